pcs_tx_multilane: RTL and testbench
===================================

Name: pcs_tx_multilane

Overview:
Parametrised transmit PCS core for multi-lane 64b/66b Ethernet (40G default, 1/2/4 lanes). Accepts pre-encoded 64-bit blocks per lane from the MAC over a ready/valid interface. It inserts idle blocks when the MAC has no data and scrambles payloads (1+x^39+x^58). It also inserts per-lane alignment markers with BIP fields every AM_PERIOD block cycles. Output feeds the per-lane tx async gearboxes, which always accept data.

Parameters:
NUM_LANES, 4, lane count; legal values 1, 2, 4.
AM_PERIOD, 16383, block cycles between markers, counting data/idle cycles only; legal range 4..65535.
SCRAMBLE, 1, 1 = scramble payloads; 0 = scrambler bypassed (debug only).

Ports:
core_clk  in  1  core clock
core_reset  in  1  reset
tx_valid  in  1  MAC has a block set on tx_data
tx_ready  out  1  block set accepted this cycle when tx_valid && tx_ready
tx_data  in  64*NUM_LANES  lane k payload at [k*64+:64]
tx_ctrl  in  NUM_LANES  bit k: 1 = lane k is a control block (byte 0 = block type), 0 = data block
tx_lane_data  out  66*NUM_LANES  lane k block at [k*66+:66]; [1:0] sync header, [65:2] payload
tx_lane_am  out  1  current output cycle is an alignment marker
am_sent  out  1  one-cycle pulse per marker cycle, coincident with tx_lane_am

Behaviour:
- Interface: reset core_reset, asynchronous, active-high; clock core_clk.
- Reset values:
  - tx_lane_data = 0, tx_lane_am = 0, am_sent = 0, tx_ready = 0.
  - Scrambler state = 58'h3FF_FFFF_FFFF_FFFF.
  - AM counter = 0; BIP accumulators = 0.
  - FSM state = S_AM.
- FSM states:
  - S_AM: marker cycle. tx_ready = 0. Goes to S_RUN next cycle.
  - S_RUN: tx_ready = 1. Counter increments each cycle. When counter == AM_PERIOD-1, counter wraps to 0 and next state is S_AM.
- First cycle after reset release is always a marker.
- tx_ready is a pure function of FSM state. It does not depend on tx_valid.
- Latency: all outputs registered; a block set accepted in cycle N appears on tx_lane_data in cycle N+1.
- Run cycle with tx_valid = 1:
  - Payload = tx_data lane slice.
  - Sync = 2'b01 if tx_ctrl[k], else 2'b10.
- Run cycle with tx_valid = 0: every lane emits an idle control block, payload 64'h0000_0000_0000_001E, sync 2'b01. Counts as a block cycle.
- Scrambling:
  - Lane payloads are scrambled serially in lane order 0..NUM_LANES-1, LSB first, over 64*NUM_LANES bits per cycle.
  - The state advances only on S_RUN cycles.
  - Sync headers are never scrambled.
- Marker block, lane k (k ≤ 3):
  - Sync = 2'b01.
  - Payload bytes 0..7 = {M0, M1, M2, BIP3, ~M0, ~M1, ~M2, ~BIP3}.
  - M0/M1/M2 per lane: lane0 90/76/47, lane1 F0/C4/E6, lane2 C5/65/9B, lane3 A2/79/3D.
  - Markers are not scrambled.
- BIP3 for lane k: bit b = XOR of every 66-bit lane block emitted since, and including, the previous marker.
  - Covers block bits j ≥ 2 with (j-2) mod 8 == b.
  - Bit 3 additionally covers sync bit 0; bit 4 additionally covers sync bit 1.
  - The accumulator reloads with the marker just sent. The first marker after reset uses BIP3 = 0.
- am_sent / tx_lane_am assert in the output cycle that carries the marker.
- Reset mid-frame: the in-flight block is discarded. The MAC must re-send the frame; no partial-state recovery is provided.

Optional Feature:
PCS_TX_BIP_EN:
- Defined: BIP3 computed as above.
- Undefined: BIP accumulators removed; BIP3 byte = 8'h00 and ~BIP3 byte = 8'hFF in every marker.

Test Plan:
1. Reset release, tx_valid = 0, AM_PERIOD = 8 → cycle 1 output is a marker with lane0 payload bytes 90,76,47,00,6F,89,B8,FF. Then 8 idle cycles (sync 01, scrambled 0x1E payload), then another marker; am_sent pulses exactly every 9 cycles.
2. tx_valid held 1 with incrementing tx_data → tx_ready low only on marker cycles; no block dropped or duplicated. Output order equals input order at 1-cycle latency.
3. SCRAMBLE = 0, tx_ctrl = 4'b0001, tx_data lane0 = 64'h...1E, lanes 1–3 = 64'hDEADBEEF_CAFEF00D → lane0 sync 01, lanes 1–3 sync 10, payloads unchanged.
4. SCRAMBLE = 1, all-zero data from reset state → output matches the golden serial 1+x^39+x^58 model seeded all-ones across lanes 0..3. State unchanged across marker cycles.
5. PCS_TX_BIP_EN, known data between markers → BIP3 in the second marker matches the reference bit-interleaved parity per lane, and ~BIP3 is its exact complement.
6. Assert core_reset mid-run with tx_valid = 1 → outputs go to 0 immediately (async). After release the first block is a marker and the scrambler restarts from the all-ones seed.

Source files
------------

// File: rtl/pcs_tx_multilane_if.sv
// pcs_tx_multilane_if: MAC-side block bus and gearbox-side lane bus of the
// multi-lane 64b/66b transmit PCS.
//   tx_valid/tx_ready  : block-set handshake (transfer on valid && ready)
//   tx_data            : lane k 64-bit payload at [k*64+:64]
//   tx_ctrl            : bit k set = lane k carries a control block
//   tx_lane_data       : lane k 66-bit block at [k*66+:66], [1:0] = sync
//   tx_lane_am/am_sent : current output cycle carries alignment markers
// master = MAC/gearbox side, slave = PCS core.
interface pcs_tx_multilane_if #(parameter int NUM_LANES = 4);
  logic                      tx_valid;
  logic                      tx_ready;
  logic [64*NUM_LANES-1:0]   tx_data;
  logic [NUM_LANES-1:0]      tx_ctrl;
  logic [66*NUM_LANES-1:0]   tx_lane_data;
  logic                      tx_lane_am;
  logic                      am_sent;

  modport master (output tx_valid, tx_data, tx_ctrl,
                  input  tx_ready, tx_lane_data, tx_lane_am, am_sent);
  modport slave  (input  tx_valid, tx_data, tx_ctrl,
                  output tx_ready, tx_lane_data, tx_lane_am, am_sent);
endinterface

// File: rtl/pcs_tx_multilane.sv
// pcs_tx_multilane: transmit PCS for 1/2/4-lane 64b/66b Ethernet.
// Takes one 64-bit block per lane from the MAC, substitutes idle control
// blocks when the MAC has nothing, scrambles payloads with a single
// 1+x^39+x^58 scrambler run serially across lanes 0..N-1, and replaces one
// block cycle every AM_PERIOD+1 with per-lane alignment markers.
// Ports:
//   core_clk   : core clock
//   core_reset : asynchronous, active-high reset
//   bus        : pcs_tx_multilane_if.slave (MAC handshake + lane outputs)
// Parameters: NUM_LANES (1/2/4), AM_PERIOD (4..65535 block cycles between
// markers), SCRAMBLE (0 bypasses the scrambler, debug only).
// Build option: define PCS_TX_BIP_EN to carry real BIP3 parity in markers;
// otherwise markers carry BIP3 = 8'h00 / ~BIP3 = 8'hFF.

// Per-lane output stage: picks marker or scrambled block, registers it and
// keeps that lane's bit-interleaved parity since the previous marker.
module pcs_tx_lane #(parameter int LANE = 0) (
  input  logic        core_clk,
  input  logic        core_reset,
  input  logic        is_am,
  input  logic [1:0]  sync,
  input  logic [63:0] payload,
  output logic [65:0] blk_o
);
  logic [65:0] blk_q, blk_d;
  logic [7:0]  marker_bip;

  // {M2, M1, M0} so that M0 lands in payload byte 0
  function automatic logic [23:0] am_code(input int k);
    case (k)
      0:       am_code = 24'h477690;
      1:       am_code = 24'hE6C4F0;
      2:       am_code = 24'h9B65C5;
      default: am_code = 24'h3D79A2;
    endcase
  endfunction

  localparam logic [23:0] AM_M = am_code(LANE);

`ifdef PCS_TX_BIP_EN
  logic [7:0] bip_q, bip_d, blk_bip;
  assign marker_bip = bip_q;
`else
  assign marker_bip = 8'h00;
`endif

  always_comb begin
    if (is_am) blk_d = {~marker_bip, ~AM_M, marker_bip, AM_M, 2'b01};
    else       blk_d = {payload, sync};
`ifdef PCS_TX_BIP_EN
    // Bit b of BIP covers payload bit b of every byte; sync bits fold
    // into BIP bits 3 and 4.
    blk_bip = 8'h00;
    for (int i = 0; i < 8; i++) blk_bip = blk_bip ^ blk_d[2+8*i +: 8];
    blk_bip[3] = blk_bip[3] ^ blk_d[0];
    blk_bip[4] = blk_bip[4] ^ blk_d[1];
    // A marker restarts the window, seeded with the marker's own parity.
    bip_d = is_am ? blk_bip : (bip_q ^ blk_bip);
`endif
  end

  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      blk_q <= '0;
`ifdef PCS_TX_BIP_EN
      bip_q <= '0;
`endif
    end else begin
      blk_q <= blk_d;
`ifdef PCS_TX_BIP_EN
      bip_q <= bip_d;
`endif
    end
  end

  assign blk_o = blk_q;
endmodule

module pcs_tx_multilane #(
  parameter int NUM_LANES = 4,
  parameter int AM_PERIOD = 16383,
  parameter int SCRAMBLE  = 1
) (
  input logic               core_clk,
  input logic               core_reset,
  pcs_tx_multilane_if.slave bus
);
  localparam int          NB   = 64 * NUM_LANES;
  localparam logic [63:0] IDLE = 64'h0000_0000_0000_001E;

  typedef enum logic {S_AM, S_RUN} state_t;

  state_t                        state_q, state_d;
  logic [15:0]                   cnt_q, cnt_d;
  logic [57:0]                   scr_q, scr_d;
  logic                          am_q, am_d;
  logic                          run;
  logic [NB-1:0]                 raw, scr_out;
  logic [NUM_LANES-1:0][1:0]     sync;
  logic [NUM_LANES-1:0][65:0]    lane_blk;

  assign run = (state_q == S_RUN);

  // Marker cycles are not block cycles: the counter only runs in S_RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_AM:  state_d = S_RUN;
      S_RUN: begin
        if (cnt_q == 16'(AM_PERIOD - 1)) begin
          cnt_d   = '0;
          state_d = S_AM;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_AM;
    endcase
  end

  // Idle cycles send the idle control block on every lane.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      raw[k*64 +: 64] = bus.tx_valid ? bus.tx_data[k*64 +: 64] : IDLE;
      sync[k]         = (!bus.tx_valid || bus.tx_ctrl[k]) ? 2'b01 : 2'b10;
    end
  end

  // Self-synchronous scrambler, one bit at a time in lane order, LSB first.
  // State holds only across marker cycles so markers leave no gap in it.
  always_comb begin
    logic [57:0]   s;
    logic [NB-1:0] o;
    s = scr_q;
    o = raw;
    if (SCRAMBLE != 0) begin
      for (int i = 0; i < NB; i++) begin
        o[i] = raw[i] ^ s[38] ^ s[57];
        s    = {s[56:0], o[i]};
      end
    end
    scr_out = o;
    scr_d   = run ? s : scr_q;
    am_d    = !run;
  end

  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      state_q <= S_AM;
      cnt_q   <= '0;
      scr_q   <= '1;
      am_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scr_q   <= scr_d;
      am_q    <= am_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    pcs_tx_lane #(.LANE(k)) u_lane (
      .core_clk   (core_clk),
      .core_reset (core_reset),
      .is_am      (!run),
      .sync       (sync[k]),
      .payload    (scr_out[k*64 +: 64]),
      .blk_o      (lane_blk[k])
    );
  end

  assign bus.tx_ready     = run;
  assign bus.tx_lane_data = lane_blk;
  assign bus.tx_lane_am   = am_q;
  assign bus.am_sent      = am_q;
endmodule

// File: tb/tb_pcs_tx_multilane.sv
// Bench for pcs_tx_multilane: two instances (4 lanes / AM_PERIOD 8 /
// scrambled, and 2 lanes / AM_PERIOD 5 / bypass) driven with directed and
// random block streams, checked every cycle against a bit-stream model.
module tb_pcs_tx_multilane;
  localparam int P0 = 8;
  localparam int P1 = 5;

  logic core_clk = 1'b0;
  logic core_reset = 1'b1;
  always #5 core_clk = ~core_clk;

  pcs_tx_multilane_if #(.NUM_LANES(4)) if0 ();
  pcs_tx_multilane_if #(.NUM_LANES(2)) if1 ();

  pcs_tx_multilane #(.NUM_LANES(4), .AM_PERIOD(P0), .SCRAMBLE(1)) dut0 (
    .core_clk(core_clk), .core_reset(core_reset), .bus(if0));
  pcs_tx_multilane #(.NUM_LANES(2), .AM_PERIOD(P1), .SCRAMBLE(0)) dut1 (
    .core_clk(core_clk), .core_reset(core_reset), .bus(if1));

  int checks = 0;
  int errors = 0;
  bit done = 0;

  // ---------------- model ----------------
  int          nl  [2] = '{4, 2};
  int          per [2] = '{P0, P1};
  bit          scr [2] = '{1'b1, 1'b0};
  int          t   [2];              // clock edges since reset release
  int          n   [2];              // scrambled bits produced so far
  bit          ring[2][64];          // recent scrambled bit history
  logic [7:0]  bip [2][4];
  logic [65:0] exp_blk[2][4];
  bit          exp_am [2];

  function automatic logic [23:0] am_m(input int k);
    logic [23:0] tab [4];
    tab = '{24'h477690, 24'hE6C4F0, 24'h9B65C5, 24'h3D79A2};
    return tab[k];
  endfunction

  function automatic logic [7:0] bip_of(input logic [65:0] blk);
    logic [7:0] p;
    p = 8'h00;
    for (int j = 2; j < 66; j++) p[(j-2) % 8] = p[(j-2) % 8] ^ blk[j];
    p[3] = p[3] ^ blk[0];
    p[4] = p[4] ^ blk[1];
    return p;
  endfunction

  task automatic model_reset(input int i);
    t[i] = 0;
    n[i] = 0;
    exp_am[i] = 1'b0;
    for (int j = 0; j < 64; j++) ring[i][j] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bip[i][k] = 8'h00;
      exp_blk[i][k] = '0;
    end
  endtask

  task automatic model_step(input int i, input logic v, input logic [255:0] d,
                            input logic [3:0] c);
    logic [63:0] pay, rw;
    logic [7:0]  b;
    logic [1:0]  sy;
    bit          x;
    if ((t[i] % (per[i] + 1)) == 0) begin
      for (int k = 0; k < nl[i]; k++) begin
`ifdef PCS_TX_BIP_EN
        b = bip[i][k];
`else
        b = 8'h00;
`endif
        exp_blk[i][k] = {~b, ~am_m(k), b, am_m(k), 2'b01};
        bip[i][k] = bip_of(exp_blk[i][k]);
      end
      exp_am[i] = 1'b1;
    end else begin
      for (int k = 0; k < nl[i]; k++) begin
        rw = v ? d[k*64 +: 64] : 64'h1E;
        sy = (!v || c[k]) ? 2'b01 : 2'b10;
        for (int j = 0; j < 64; j++) begin
          if (scr[i]) begin
            x = rw[j] ^ ring[i][(n[i] - 39) & 63] ^ ring[i][(n[i] - 58) & 63];
            ring[i][n[i] & 63] = x;
            n[i]++;
            pay[j] = x;
          end else begin
            pay[j] = rw[j];
          end
        end
        exp_blk[i][k] = {pay, sy};
        bip[i][k] = bip[i][k] ^ bip_of(exp_blk[i][k]);
      end
      exp_am[i] = 1'b0;
    end
    t[i]++;
  endtask

  always @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, if0.tx_valid, if0.tx_data, if0.tx_ctrl);
      model_step(1, if1.tx_valid, {128'b0, if1.tx_data}, {2'b0, if1.tx_ctrl});
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic [263:0] ld, input logic rdy,
                            input logic am, input logic sent);
    if (core_reset) begin
      chk($sformatf("rst_data%0d", i), 66'(ld == '0), 66'd1);
      chk($sformatf("rst_am%0d", i), 66'(am), 66'd0);
      chk($sformatf("rst_sent%0d", i), 66'(sent), 66'd0);
      chk($sformatf("rst_ready%0d", i), 66'(rdy), 66'd0);
    end else begin
      for (int k = 0; k < nl[i]; k++)
        chk($sformatf("blk%0d_l%0d", i, k), ld[k*66 +: 66], exp_blk[i][k]);
      chk($sformatf("am%0d", i), 66'(am), 66'(exp_am[i]));
      chk($sformatf("sent%0d", i), 66'(sent), 66'(exp_am[i]));
      chk($sformatf("ready%0d", i), 66'(rdy), 66'((t[i] % (per[i] + 1)) != 0));
    end
  endtask

  always @(negedge core_clk) begin
    if (!done) begin
      check_inst(0, if0.tx_lane_data, if0.tx_ready, if0.tx_lane_am, if0.am_sent);
      check_inst(1, {132'b0, if1.tx_lane_data}, if1.tx_ready, if1.tx_lane_am, if1.am_sent);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_rand();
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
    if0.tx_valid = ($urandom_range(0, 9) < 7);
    if0.tx_data  = d;
    if0.tx_ctrl  = 4'($urandom);
    if1.tx_valid = ($urandom_range(0, 9) < 5);
    if1.tx_data  = {$urandom, $urandom, $urandom, $urandom};
    if1.tx_ctrl  = 2'($urandom);
  endtask

  task automatic drive_zero_directed();
    if0.tx_valid = 1'b1;
    if0.tx_data  = '0;
    if0.tx_ctrl  = 4'b0000;
    if1.tx_valid = 1'b1;
    if1.tx_data  = {64'hDEADBEEF_CAFEF00D, 64'h0000_0000_0000_001E};
    if1.tx_ctrl  = 2'b01;
  endtask

  initial begin
    int pulses0, pulses1;
    logic [63:0] seq;
    bit last_rdy;
    if0.tx_valid = 1'b0; if0.tx_data = '0; if0.tx_ctrl = '0;
    if1.tx_valid = 1'b0; if1.tx_data = '0; if1.tx_ctrl = '0;
    repeat (3) @(negedge core_clk);

    // Directed: all-zero data into the scrambler, bypass lane patterns.
    drive_zero_directed();
    core_reset = 1'b0;
    @(negedge core_clk);
    chk("am_lit_l0", if0.tx_lane_data[65:0], {64'hFFB8896F_00477690, 2'b01});
    chk("am_lit_l3", if0.tx_lane_data[263:198],
        {8'hFF, ~24'h3D79A2, 8'h00, 24'h3D79A2, 2'b01});
    @(negedge core_clk);
    chk("scr_lit_l0", if0.tx_lane_data[65:0], {64'h03FFFF80_00000000, 2'b10});
    chk("byp_l0", if1.tx_lane_data[65:0], {64'h0000_0000_0000_001E, 2'b01});
    chk("byp_l1", if1.tx_lane_data[131:66], {64'hDEADBEEF_CAFEF00D, 2'b10});
    pulses0 = 0;
    pulses1 = 0;
    repeat (18) begin
      @(negedge core_clk);
      if (if0.am_sent) pulses0++;
      if (if1.am_sent) pulses1++;
    end
    chk("am_cnt0", 66'(pulses0), 66'd2);
    chk("am_cnt1", 66'(pulses1), 66'd3);

    // Back-to-back stream with incrementing data, advanced only on transfer.
    seq = 64'd0;
    last_rdy = 1'b0;
    repeat (60) begin
      if (last_rdy) seq = seq + 64'd1;
      if0.tx_valid = 1'b1;
      for (int k = 0; k < 4; k++) if0.tx_data[k*64 +: 64] = seq * 4 + 64'(k);
      if0.tx_ctrl = 4'b0000;
      if1.tx_valid = 1'b1;
      if1.tx_data  = {seq, ~seq};
      if1.tx_ctrl  = 2'b10;
      last_rdy = if0.tx_ready;
      @(negedge core_clk);
    end

    // Random traffic.
    repeat (400) begin
      drive_rand();
      @(negedge core_clk);
    end

    // Asynchronous reset in the middle of a busy cycle.
    if0.tx_valid = 1'b1; if0.tx_data = {8{32'hA5A5_0F0F}};
    @(posedge core_clk);
    #3 core_reset = 1'b1;
    #1;
    chk("mid_rst_data", 66'(if0.tx_lane_data == '0), 66'd1);
    chk("mid_rst_ready", 66'(if0.tx_ready), 66'd0);
    chk("mid_rst_am", 66'(if0.am_sent), 66'd0);
    @(negedge core_clk);
    @(negedge core_clk);
    drive_zero_directed();
    core_reset = 1'b0;
    @(negedge core_clk);
    chk("rst_am_lit", if0.tx_lane_data[65:0], {64'hFFB8896F_00477690, 2'b01});
    @(negedge core_clk);
    chk("rst_scr_lit", if0.tx_lane_data[65:0], {64'h03FFFF80_00000000, 2'b10});

    repeat (150) begin
      drive_rand();
      @(negedge core_clk);
    end

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
